// File: rtl/conv_writeback.sv
// conv_writeback: buffers 4-channel result pixels in a small FIFO and
// serialises each pixel into four single-word memory writes (lane 0..3).
// Address = per-channel base + row + col*out_size (raster order).
// Build option: define CONV_WB_RELU_EN to clamp negative channel words to
// zero at the FIFO output (same timing either way).
`timescale 1ns/1ps
module conv_writeback #(
    parameter int DataWidth    = 32,
    parameter int MaxAddrWidth = 32,
    parameter int MaxPictWidth = 9,
    parameter int MaxPixelNum  = 18,
    parameter int FifoDepth    = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    inst_tag_in,
    input  logic [MaxAddrWidth-1:0] out_addr0_in,
    input  logic [MaxAddrWidth-1:0] out_addr1_in,
    input  logic [MaxAddrWidth-1:0] out_addr2_in,
    input  logic [MaxAddrWidth-1:0] out_addr3_in,
    input  logic [MaxPictWidth-1:0] out_size_in,
    input  logic [4*DataWidth-1:0]  result_in,
    input  logic                    result_valid_in,
    output logic                    result_ready_out,
    output logic [MaxAddrWidth-1:0] write_addr_out,
    output logic [DataWidth-1:0]    write_wdata_out,
    output logic                    write_en_out,
    input  logic                    write_ready_in,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    overflow_out
);
    localparam int PTR_W = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FifoDepth);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r, state_nx;
    logic                    tag_dly_r;
    logic [MaxAddrWidth-1:0] base_r [4];
    logic [MaxPictWidth-1:0] size_r;
    logic [4*DataWidth-1:0]  mem_r [FifoDepth];
    logic [PTR_W-1:0]        wr_ptr_r, wr_ptr_nx, rd_ptr_r, rd_ptr_nx;
    logic [CNT_W-1:0]        count_r, count_nx, remain_s;
    logic [1:0]              lane_r, lane_nx;
    logic [MaxPictWidth-1:0] row_r, row_nx, col_r, col_nx;
    logic [MaxPixelNum-1:0]  accum_r, accum_nx;
    logic                    overflow_r;
    logic                    wen_r, wen_nx;
    logic [MaxAddrWidth-1:0] waddr_r, waddr_nx, base_sel_s;
    logic [DataWidth-1:0]    wdata_r, wdata_nx, word_sel_s;
    logic [4*DataWidth-1:0]  head_s;

    logic inst_changed_s, run_s, start_s, accept_s, pop_s, push_s, ovf_set_s, last_pix_s;
    logic [MaxPictWidth-1:0] size_m1_s;

    // Negative words become zero when the clamp is built in.
    function automatic logic [DataWidth-1:0] relu_f(input logic [DataWidth-1:0] w);
`ifdef CONV_WB_RELU_EN
        relu_f = w[DataWidth-1] ? {DataWidth{1'b0}} : w;
`else
        relu_f = w;
`endif
    endfunction

    assign inst_changed_s   = inst_tag_in ^ tag_dly_r;
    assign run_s            = (state_r == ST_RUN);
    assign start_s          = (state_r != ST_RUN) && inst_changed_s;
    assign accept_s         = wen_r && write_ready_in;
    assign pop_s            = accept_s && (lane_r == 2'd3);
    assign size_m1_s        = size_r - MaxPictWidth'(1'b1);
    assign last_pix_s       = (row_r == size_m1_s) && (col_r == size_m1_s);
    // A full FIFO still takes a pixel when the head leaves on the same edge.
    assign push_s           = run_s && result_valid_in && ((count_r < DEPTH_C) || pop_s);
    assign ovf_set_s        = run_s && result_valid_in && (count_r == DEPTH_C) && !pop_s;
    assign result_ready_out = run_s && (count_r < DEPTH_C);
    assign busy_out         = (state_r == ST_RUN);
    assign done_out         = (state_r == ST_DONE);
    assign overflow_out     = overflow_r;
    assign write_en_out     = wen_r;
    assign write_addr_out   = waddr_r;
    assign write_wdata_out  = wdata_r;

    // Next-state decode for the IDLE/RUN/DONE controller.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (inst_changed_s) begin
                    state_nx = (out_size_in == {MaxPictWidth{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_RUN: begin
                if (pop_s && last_pix_s) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values of FIFO pointers, lane and raster counters.
    always_comb begin
        lane_nx   = lane_r;
        row_nx    = row_r;
        col_nx    = col_r;
        accum_nx  = accum_r;
        rd_ptr_nx = rd_ptr_r;
        wr_ptr_nx = wr_ptr_r;
        remain_s  = count_r - CNT_W'(pop_s);
        count_nx  = remain_s + CNT_W'(push_s);
        if (start_s) begin
            lane_nx   = 2'd0;
            row_nx    = '0;
            col_nx    = '0;
            accum_nx  = '0;
            rd_ptr_nx = '0;
            wr_ptr_nx = '0;
            remain_s  = '0;
            count_nx  = '0;
        end else begin
            if (accept_s) begin
                lane_nx = lane_r + 2'd1;
            end else begin
                lane_nx = lane_r;
            end
            if (pop_s) begin
                rd_ptr_nx = rd_ptr_r + PTR_W'(1'b1);
                if (row_r == size_m1_s) begin
                    row_nx   = '0;
                    col_nx   = col_r + MaxPictWidth'(1'b1);
                    accum_nx = accum_r + MaxPixelNum'(size_r);
                end else begin
                    row_nx   = row_r + MaxPictWidth'(1'b1);
                end
            end else begin
                rd_ptr_nx = rd_ptr_r;
            end
            if (push_s) begin
                wr_ptr_nx = wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_nx = wr_ptr_r;
            end
        end
    end

    // Next write request: built from post-edge state so a held request only
    // advances on accept; pixels pushed this edge are not yet visible.
    always_comb begin
        wen_nx = (state_nx == ST_RUN) && (remain_s != '0);
        head_s = mem_r[rd_ptr_nx];
        case (lane_nx)
            2'd0:    begin base_sel_s = base_r[0]; word_sel_s = head_s[0*DataWidth +: DataWidth]; end
            2'd1:    begin base_sel_s = base_r[1]; word_sel_s = head_s[1*DataWidth +: DataWidth]; end
            2'd2:    begin base_sel_s = base_r[2]; word_sel_s = head_s[2*DataWidth +: DataWidth]; end
            2'd3:    begin base_sel_s = base_r[3]; word_sel_s = head_s[3*DataWidth +: DataWidth]; end
            default: begin base_sel_s = base_r[0]; word_sel_s = head_s[0*DataWidth +: DataWidth]; end
        endcase
        if (wen_nx) begin
            waddr_nx = base_sel_s + MaxAddrWidth'(row_nx) + MaxAddrWidth'(accum_nx);
            wdata_nx = relu_f(word_sel_s);
        end else begin
            waddr_nx = '0;
            wdata_nx = '0;
        end
    end

    // Delayed tag so a toggle appears as a one-cycle change.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) tag_dly_r <= 1'b0;
        else     tag_dly_r <= inst_tag_in;
    end

    // Controller state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_r <= ST_IDLE;
        else     state_r <= state_nx;
    end

    // Per-instruction bases and picture size, captured on instruction start.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < 4; i++) base_r[i] <= '0;
            size_r <= '0;
        end else if (start_s) begin
            base_r[0] <= out_addr0_in;
            base_r[1] <= out_addr1_in;
            base_r[2] <= out_addr2_in;
            base_r[3] <= out_addr3_in;
            size_r    <= out_size_in;
        end
    end

    // FIFO pointers, occupancy, lane and raster counters.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            lane_r   <= 2'd0;
            row_r    <= '0;
            col_r    <= '0;
            accum_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_nx;
            rd_ptr_r <= rd_ptr_nx;
            count_r  <= count_nx;
            lane_r   <= lane_nx;
            row_r    <= row_nx;
            col_r    <= col_nx;
            accum_r  <= accum_nx;
        end
    end

    // Pixel storage.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < FifoDepth; i++) mem_r[i] <= '0;
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= result_in;
        end
    end

    // Sticky overflow, cleared when a new instruction starts.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)            overflow_r <= 1'b0;
        else if (start_s)   overflow_r <= 1'b0;
        else if (ovf_set_s) overflow_r <= 1'b1;
    end

    // Registered memory write port.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wen_r   <= 1'b0;
            waddr_r <= '0;
            wdata_r <= '0;
        end else begin
            wen_r   <= wen_nx;
            waddr_r <= waddr_nx;
            wdata_r <= wdata_nx;
        end
    end
endmodule

// File: tb/tb_conv_writeback.sv
// Testbench for conv_writeback: directed stimulus, a raster-order write
// scoreboard plus a small occupancy/status model checked every cycle.
`timescale 1ns/1ps
module tb_conv_writeback;
    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         inst_tag_in = 1'b0;
    logic [31:0]  out_addr0_in = 32'h0, out_addr1_in = 32'h0, out_addr2_in = 32'h0, out_addr3_in = 32'h0;
    logic [8:0]   out_size_in = 9'd0;
    logic [127:0] result_in = 128'h0;
    logic         result_valid_in = 1'b0;
    logic         result_ready_out;
    logic [31:0]  write_addr_out;
    logic [31:0]  write_wdata_out;
    logic         write_en_out;
    logic         write_ready_in = 1'b0;
    logic         busy_out, done_out, overflow_out;

    conv_writeback dut (
        .Clk(Clk), .Rst(Rst), .inst_tag_in(inst_tag_in),
        .out_addr0_in(out_addr0_in), .out_addr1_in(out_addr1_in),
        .out_addr2_in(out_addr2_in), .out_addr3_in(out_addr3_in),
        .out_size_in(out_size_in), .result_in(result_in),
        .result_valid_in(result_valid_in), .result_ready_out(result_ready_out),
        .write_addr_out(write_addr_out), .write_wdata_out(write_wdata_out),
        .write_en_out(write_en_out), .write_ready_in(write_ready_in),
        .busy_out(busy_out), .done_out(done_out), .overflow_out(overflow_out)
    );

    always #5 Clk = ~Clk;

`ifdef CONV_WB_RELU_EN
    localparam logic [31:0] NEG_WORD_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] NEG_WORD_EXP = 32'hFFFF_FFF0;
`endif

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t         exp_q[$];
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the instruction in flight.
    logic        m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
    int          m_pushed = 0, m_popped = 0, m_written = 0, m_total = 0, m_size = 0, pix_idx = 0;
    logic [31:0] m_base [4];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] relu_m(input logic [31:0] w);
`ifdef CONV_WB_RELU_EN
        return w[31] ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [127:0] mkpix(input int i);
        return {32'h3000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i), 32'h0000_0000 + 32'(i)};
    endfunction

    // Per-cycle compare against the model and scoreboard.
    always @(negedge Clk) begin
        wr_t e;
        chk("busy", {31'd0, busy_out}, {31'd0, m_busy});
        chk("done", {31'd0, done_out}, {31'd0, m_done});
        chk("overflow", {31'd0, overflow_out}, {31'd0, m_ovf});
        chk("ready", {31'd0, result_ready_out}, {31'd0, m_busy && ((m_pushed - m_popped) < 4)});
        if (write_en_out) chk("wen_pending", {31'd0, exp_q.size() != 0}, 32'd1);
        if (write_en_out && write_ready_in && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", write_addr_out, e.a);
            chk("wr_data", write_wdata_out, e.d);
            log_a.push_back(write_addr_out);
            log_d.push_back(write_wdata_out);
            m_written++;
            if (m_written % 4 == 0) m_popped++;
            if (m_written == m_total * 4) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start(input logic [31:0] b0, b1, b2, b3, input int size);
        out_addr0_in = b0; out_addr1_in = b1; out_addr2_in = b2; out_addr3_in = b3;
        out_size_in  = 9'(size);
        inst_tag_in  = ~inst_tag_in;
        tick();
        chk("leftover_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete(); log_a.delete(); log_d.delete();
        m_base[0] = b0; m_base[1] = b1; m_base[2] = b2; m_base[3] = b3;
        m_size = size; m_total = size * size;
        m_busy = (size != 0); m_done = (size == 0); m_ovf = 1'b0;
        m_pushed = 0; m_popped = 0; m_written = 0; pix_idx = 0;
    endtask

    // kind 0: accepted, 1: dropped with overflow, 2: dropped silently
    task automatic push(input logic [127:0] pix, input int kind);
        wr_t e;
        int  row, col;
        result_in = pix;
        result_valid_in = 1'b1;
        tick();
        result_valid_in = 1'b0;
        if (kind == 0) begin
            row = pix_idx % m_size;
            col = pix_idx / m_size;
            for (int k = 0; k < 4; k++) begin
                e.a = m_base[k] + 32'(row) + 32'(col * m_size);
                e.d = relu_m(pix[k*32 +: 32]);
                exp_q.push_back(e);
            end
            pix_idx++;
            m_pushed++;
        end else if (kind == 1) begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int i = 0;
        while (m_written < target && i < budget) begin
            tick();
            i++;
        end
        chk(name, {31'd0, m_written >= target}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        chk("rst_wen", {31'd0, write_en_out}, 32'd0);
        chk("rst_addr", write_addr_out, 32'd0);
        chk("rst_data", write_wdata_out, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_done", {31'd0, done_out}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_out}, 32'd0);
        chk("rst_ready", {31'd0, result_ready_out}, 32'd0);
        tick();
        Rst = 1'b0;
        tick();

        // 1: basic raster order, write_ready always high
        start(32'h100, 32'h200, 32'h300, 32'h400, 2);
        write_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) push(mkpix(i), 0);
        wait_writes(16, 60, "t1_drain");
        chk("t1_done", {31'd0, done_out}, 32'd1);
        chk("t1_a0", log_a[0], 32'h100);
        chk("t1_a1", log_a[1], 32'h200);
        chk("t1_a4", log_a[4], 32'h101);
        chk("t1_a15", log_a[15], 32'h403);
        chk("t1_d15", log_d[15], 32'h3000_0003);
        push(mkpix(50), 2);
        repeat (3) tick();

        // 2: stall during lane 2 of pixel 2
        start(32'h100, 32'h200, 32'h300, 32'h400, 2);
        write_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) push(mkpix(i), 0);
        write_ready_in = 1'b1;
        repeat (10) tick();
        write_ready_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t2_addr_hold", write_addr_out, 32'h302);
            chk("t2_data_hold", write_wdata_out, 32'h2000_0002);
            chk("t2_wen_hold", {31'd0, write_en_out}, 32'd1);
            tick();
        end
        write_ready_in = 1'b1;
        tick();
        chk("t2_lane3", write_addr_out, 32'h402);
        wait_writes(16, 60, "t2_drain");
        chk("t2_a10", log_a[10], 32'h302);

        // 3: overflow with FIFO full and no pops
        start(32'h1000, 32'h2000, 32'h3000, 32'h4000, 3);
        write_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) push(mkpix(i), 0);
        chk("t3_ready_full", {31'd0, result_ready_out}, 32'd0);
        push(mkpix(99), 1);
        chk("t3_ovf", {31'd0, overflow_out}, 32'd1);
        write_ready_in = 1'b1;
        wait_writes(16, 40, "t3_drain4");
        chk("t3_ovf_sticky", {31'd0, overflow_out}, 32'd1);
        for (int i = 4; i < 9; i++) begin
            push(mkpix(i), 0);
            repeat (4) tick();
        end
        wait_writes(36, 60, "t3_drain9");
        chk("t3_ovf_done", {31'd0, overflow_out}, 32'd1);
        chk("t3_a16", log_a[16], 32'h1004);
        chk("t3_a35", log_a[35], 32'h4008);
        start(32'h1, 32'h2, 32'h3, 32'h4, 0);
        chk("t3_ovf_clr", {31'd0, overflow_out}, 32'd0);
        chk("size0_done", {31'd0, done_out}, 32'd1);
        chk("size0_busy", {31'd0, busy_out}, 32'd0);
        repeat (3) tick();

        // 4: reset mid-pixel, then restart
        start(32'h100, 32'h200, 32'h300, 32'h400, 2);
        write_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) push(mkpix(i), 0);
        write_ready_in = 1'b1;
        repeat (9) tick();
        chk("t4_pre_addr", write_addr_out, 32'h202);
        chk("t4_pre_data", write_wdata_out, 32'h1000_0002);
        Rst = 1'b1;
        inst_tag_in = 1'b0;
        write_ready_in = 1'b0;
        exp_q.delete();
        m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
        m_pushed = 0; m_popped = 0; m_written = 0; m_total = 0;
        #1;
        chk("t4_rst_wen", {31'd0, write_en_out}, 32'd0);
        chk("t4_rst_busy", {31'd0, busy_out}, 32'd0);
        chk("t4_rst_done", {31'd0, done_out}, 32'd0);
        repeat (2) tick();
        Rst = 1'b0;
        tick();
        start(32'h100, 32'h200, 32'h300, 32'h400, 2);
        write_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(mkpix(i + 8), 0);
            repeat (4) tick();
        end
        wait_writes(16, 60, "t4_drain");
        chk("t4_a0", log_a[0], 32'h100);

        // 5/6: ReLU words, address wrap, tag toggle ignored in RUN, restart from DONE
        start(32'hFFFF_FFFF, 32'h10, 32'h20, 32'h30, 2);
        write_ready_in = 1'b1;
        push({32'h0000_0003, 32'h0000_0002, 32'h7FFF_FFFF, 32'hFFFF_FFF0}, 0);
        repeat (2) tick();
        inst_tag_in = ~inst_tag_in;
        tick();
        for (int i = 1; i < 4; i++) begin
            push(mkpix(i), 0);
            repeat (4) tick();
        end
        wait_writes(16, 60, "t6_drain");
        chk("t5_neg_word", log_d[0], NEG_WORD_EXP);
        chk("t5_pos_word", log_d[1], 32'h7FFF_FFFF);
        chk("t6_a0", log_a[0], 32'hFFFF_FFFF);
        chk("t6_wrap", log_a[4], 32'h0000_0000);
        chk("t6_done", {31'd0, done_out}, 32'd1);
        start(32'h500, 32'h600, 32'h700, 32'h800, 1);
        chk("t6_busy_next", {31'd0, busy_out}, 32'd1);
        push(mkpix(7), 0);
        wait_writes(4, 30, "t6_drain2");
        chk("t6_restart_a0", log_a[0], 32'h500);
        chk("t6_restart_done", {31'd0, done_out}, 32'd1);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
